// File: rtl/eros_mem_xbar_if.sv
// Bus bundle between OBI masters, the memory crossbar and its SRAM banks.
// The slave modport is the crossbar's view; master is the surrounding system's view.
interface eros_mem_xbar_if #(
    parameter int NMASTERS = 3,
    parameter int N_BANKS  = 2,
    parameter int BANK_AW  = 13
);
    logic [NMASTERS-1:0]         m_req_i;
    logic [NMASTERS-1:0]         m_gnt_o;
    logic [NMASTERS*32-1:0]      m_addr_i;
    logic [NMASTERS-1:0]         m_we_i;
    logic [NMASTERS*4-1:0]       m_be_i;
    logic [NMASTERS*32-1:0]      m_wdata_i;
    logic [NMASTERS-1:0]         m_rvalid_o;
    logic [NMASTERS*32-1:0]      m_rdata_o;
    logic [NMASTERS-1:0]         m_err_o;
    logic [N_BANKS-1:0]          b_req_o;
    logic [N_BANKS-1:0]          b_we_o;
    logic [N_BANKS*4-1:0]        b_be_o;
    logic [N_BANKS*BANK_AW-1:0]  b_addr_o;
    logic [N_BANKS*32-1:0]       b_wdata_o;
    logic [N_BANKS*32-1:0]       b_rdata_i;
    logic [N_BANKS-1:0]          bank_pwr_on_i;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, b_rdata_i, bank_pwr_on_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        output b_req_o, b_we_o, b_be_o, b_addr_o, b_wdata_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, b_rdata_i, bank_pwr_on_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        input  b_req_o, b_we_o, b_be_o, b_addr_o, b_wdata_o
    );
endinterface

// File: rtl/eros_mem_xbar.sv
// OBI crossbar: NMASTERS masters to N_BANKS SRAM banks, per-bank round-robin, gated/out-of-range -> error.
// Latency: grant same cycle, response 1 cycle after grant; one access per bank per cycle.
// Backpressure: losers see gnt=0 and hold; EROS_XBAR_PERF_EN adds per-bank conflict counters.
module eros_mem_xbar #(
    parameter int NMASTERS    = 3,
    parameter int N_BANKS     = 2,
    parameter int BANK_AW     = 13,
    parameter int INTERLEAVED = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    eros_mem_xbar_if.slave         bus
`ifdef EROS_XBAR_PERF_EN
    ,
    input  logic                   perf_clr_i,
    output logic [N_BANKS*32-1:0]  perf_conflict_o
`endif
);
    localparam int LB  = (N_BANKS > 1) ? $clog2(N_BANKS) : 0;
    localparam int LBW = (LB > 0) ? LB : 1;
    localparam int MW  = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam logic [31:0] N_WORDS = 32'(N_BANKS) << BANK_AW;

    logic [29:0]         w       [NMASTERS];
    logic [LBW-1:0]      m_bank  [NMASTERS];
    logic [BANK_AW-1:0]  m_baddr [NMASTERS];
    logic [NMASTERS-1:0] m_ok;
    logic [NMASTERS-1:0] m_err_req;
    logic [NMASTERS-1:0] unused_addr_lsb;

    logic [NMASTERS-1:0] b_reqv   [N_BANKS];
    logic [N_BANKS-1:0]  win_vld;
    logic [MW-1:0]       win_idx  [N_BANKS];
    logic [MW-1:0]       rr_ptr   [N_BANKS];
    logic [N_BANKS-1:0]  rsp_vld;
    logic [N_BANKS-1:0]  rsp_we;
    logic [MW-1:0]       rsp_idx  [N_BANKS];
    logic [NMASTERS-1:0] err_q;

    for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_dec
        assign w[gi] = bus.m_addr_i[gi*32+2 +: 30];
        assign unused_addr_lsb[gi] = ^bus.m_addr_i[gi*32 +: 2];
        if (LB == 0) begin : g_single
            assign m_bank[gi]  = '0;
            assign m_baddr[gi] = w[gi][BANK_AW-1:0];
        end else if (INTERLEAVED != 0) begin : g_ilv
            assign m_bank[gi]  = w[gi][LB-1:0];
            assign m_baddr[gi] = w[gi][LB +: BANK_AW];
        end else begin : g_cont
            assign m_bank[gi]  = w[gi][BANK_AW +: LB];
            assign m_baddr[gi] = w[gi][BANK_AW-1:0];
        end
        // Out-of-range and powered-down targets never reach an arbiter.
        assign m_ok[gi] = bus.m_req_i[gi] && ({2'b00, w[gi]} < N_WORDS)
                          && bus.bank_pwr_on_i[m_bank[gi]];
        assign m_err_req[gi] = bus.m_req_i[gi] && !m_ok[gi];
    end

    always_comb begin
        int idx;
        idx = 0;
        for (int b = 0; b < N_BANKS; b++) begin
            b_reqv[b]  = '0;
            win_vld[b] = 1'b0;
            win_idx[b] = '0;
            for (int i = 0; i < NMASTERS; i++) begin
                if (m_ok[i] && (m_bank[i] == LBW'(b))) b_reqv[b][i] = 1'b1;
            end
            // Search starts at the pointer so the master sitting there has top priority.
            for (int k = 0; k < NMASTERS; k++) begin
                idx = int'(rr_ptr[b]) + k;
                if (idx >= NMASTERS) idx = idx - NMASTERS;
                if (!win_vld[b] && b_reqv[b][idx]) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = MW'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.m_gnt_o   = m_err_req;
        bus.b_req_o   = '0;
        bus.b_we_o    = '0;
        bus.b_be_o    = '0;
        bus.b_addr_o  = '0;
        bus.b_wdata_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (win_vld[b]) begin
                bus.m_gnt_o[win_idx[b]]             = 1'b1;
                bus.b_req_o[b]                      = 1'b1;
                bus.b_we_o[b]                       = bus.m_we_i[win_idx[b]];
                bus.b_be_o[b*4 +: 4]                = bus.m_be_i[int'(win_idx[b])*4 +: 4];
                bus.b_addr_o[b*BANK_AW +: BANK_AW]  = m_baddr[win_idx[b]];
                bus.b_wdata_o[b*32 +: 32]           = bus.m_wdata_i[int'(win_idx[b])*32 +: 32];
            end
        end
        if (rst_i) begin
            bus.m_gnt_o = '0;
            bus.b_req_o = '0;
            bus.b_we_o  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < N_BANKS; b++) begin
                rr_ptr[b]  <= '0;
                rsp_idx[b] <= '0;
            end
            rsp_vld <= '0;
            rsp_we  <= '0;
            err_q   <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                rsp_vld[b] <= win_vld[b];
                if (win_vld[b]) begin
                    rsp_idx[b] <= win_idx[b];
                    rsp_we[b]  <= bus.m_we_i[win_idx[b]];
                    rr_ptr[b]  <= (int'(win_idx[b]) == NMASTERS-1) ? '0 : win_idx[b] + MW'(1);
                end
            end
            err_q <= m_err_req;
        end
    end

    always_comb begin
        bus.m_rvalid_o = err_q;
        bus.m_err_o    = err_q;
        bus.m_rdata_o  = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (rsp_vld[b]) begin
                bus.m_rvalid_o[rsp_idx[b]] = 1'b1;
                if (!rsp_we[b]) bus.m_rdata_o[int'(rsp_idx[b])*32 +: 32] = bus.b_rdata_i[b*32 +: 32];
            end
        end
    end

`ifdef EROS_XBAR_PERF_EN
    logic [31:0] perf_cnt [N_BANKS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < N_BANKS; b++) perf_cnt[b] <= '0;
        end else if (perf_clr_i) begin
            for (int b = 0; b < N_BANKS; b++) perf_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                // Clearing the lowest set bit leaves something only when two or more contend.
                if ((|(b_reqv[b] & (b_reqv[b] - NMASTERS'(1)))) && (perf_cnt[b] != 32'hFFFF_FFFF))
                    perf_cnt[b] <= perf_cnt[b] + 32'd1;
            end
        end
    end

    for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_perf
        assign perf_conflict_o[gb*32 +: 32] = perf_cnt[gb];
    end
`endif
endmodule
